// File: rtl/i2s_clock_generator_if.sv
`default_nettype none
// ============================================================================
// i2s_clock_generator_if : control inputs and clock/strobe outputs of the
//                          I2S clock generator
// Revision: 1.0
// ============================================================================
interface i2s_clock_generator_if #(
  parameter int DIVIDER_WIDTH = 8
);
  logic                     i_ENABLE;
  logic [DIVIDER_WIDTH-1:0] i_DIVIDER;
  logic                     o_SCK;
  logic                     o_WS;
  logic                     o_SCK_RISE;
  logic                     o_SCK_FALL;
  logic                     o_FRAME_START;
  logic                     o_BUSY;

  modport master (
    output i_ENABLE, i_DIVIDER,
    input  o_SCK, o_WS, o_SCK_RISE, o_SCK_FALL, o_FRAME_START, o_BUSY
  );

  modport slave (
    input  i_ENABLE, i_DIVIDER,
    output o_SCK, o_WS, o_SCK_RISE, o_SCK_FALL, o_FRAME_START, o_BUSY
  );
endinterface
`default_nettype wire

// File: rtl/i2s_clock_generator.sv
`default_nettype none
// ============================================================================
// i2s_clock_generator : divides i_CLK into I2S SCK/WS with edge and frame
//                       strobes; starts and stops only on frame boundaries
// Revision: 1.0
// ============================================================================
module i2s_clock_generator #(
  parameter int DATA_WIDTH    = 16,
  parameter int DIVIDER_WIDTH = 8
) (
  input logic                  i_CLK,
  input logic                  i_NRESET,
  i2s_clock_generator_if.slave bus
);

  localparam int BC_W = $clog2(2 * DATA_WIDTH);
  localparam logic [BC_W-1:0] c_BC_LAST = BC_W'(2 * DATA_WIDTH - 1);
  localparam logic [BC_W-1:0] c_BC_HALF = BC_W'(DATA_WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t                   r_state, w_state_nxt;
  logic [DIVIDER_WIDTH-1:0] r_hc, w_hc_nxt;
  logic [DIVIDER_WIDTH-1:0] r_divl, w_divl_nxt;
  logic [BC_W-1:0]          r_bc, w_bc_nxt;
  logic                     r_sck, w_sck_nxt;
  logic                     r_ws, w_ws_nxt;
  logic                     r_rise, w_rise_nxt;
  logic                     r_fall, w_fall_nxt;
  logic                     r_fs, w_fs_nxt;
  logic                     r_busy;
  logic [BC_W-1:0]          w_bc_inc;

  assign w_bc_inc = r_bc + 1'b1;

  always_ff @(posedge i_CLK or negedge i_NRESET) begin
    if (!i_NRESET) begin
      r_state <= ST_IDLE;
      r_hc    <= '0;
      r_divl  <= '0;
      r_bc    <= '0;
      r_sck   <= 1'b0;
      r_ws    <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
      r_fs    <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_hc    <= w_hc_nxt;
      r_divl  <= w_divl_nxt;
      r_bc    <= w_bc_nxt;
      r_sck   <= w_sck_nxt;
      r_ws    <= w_ws_nxt;
      r_rise  <= w_rise_nxt;
      r_fall  <= w_fall_nxt;
      r_fs    <= w_fs_nxt;
      r_busy  <= (w_state_nxt != ST_IDLE);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_hc_nxt    = r_hc;
    w_divl_nxt  = r_divl;
    w_bc_nxt    = r_bc;
    w_sck_nxt   = r_sck;
    w_ws_nxt    = r_ws;
    w_rise_nxt  = 1'b0;
    w_fall_nxt  = 1'b0;
    w_fs_nxt    = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        w_sck_nxt = 1'b0;
        w_ws_nxt  = 1'b0;
        if (bus.i_ENABLE) begin
          w_state_nxt = ST_RUN;
          w_hc_nxt    = '0;
          w_bc_nxt    = '0;
          w_divl_nxt  = bus.i_DIVIDER;
          w_fs_nxt    = 1'b1;
        end
      end

      ST_RUN, ST_DRAIN: begin
        // RUN and DRAIN share the datapath; only the boundary action differs.
        w_state_nxt = bus.i_ENABLE ? ST_RUN : ST_DRAIN;
        if (r_hc == r_divl) begin
          w_hc_nxt  = '0;
          w_sck_nxt = ~r_sck;
          if (!r_sck) begin
            w_rise_nxt = 1'b1;
          end else begin
            w_fall_nxt = 1'b1;
            if (r_bc == c_BC_LAST) begin
              w_bc_nxt = '0;
              w_ws_nxt = 1'b0;
              // A draining generator that is still disabled stops here
              // instead of opening another frame.
              if (r_state == ST_DRAIN && !bus.i_ENABLE) begin
                w_state_nxt = ST_IDLE;
              end else begin
                w_fs_nxt   = 1'b1;
                w_divl_nxt = bus.i_DIVIDER;
              end
            end else begin
              w_bc_nxt = w_bc_inc;
              w_ws_nxt = (w_bc_inc >= c_BC_HALF);
            end
          end
        end else begin
          w_hc_nxt = r_hc + 1'b1;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign bus.o_SCK         = r_sck;
  assign bus.o_WS          = r_ws;
  assign bus.o_SCK_RISE    = r_rise;
  assign bus.o_SCK_FALL    = r_fall;
  assign bus.o_FRAME_START = r_fs;
  assign bus.o_BUSY        = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_i2s_clock_generator.sv
`default_nettype none
// ============================================================================
// tb_i2s_clock_generator : directed self-checking bench for i2s_clock_generator
// Revision: 1.0
// ============================================================================
module tb_i2s_clock_generator;

  logic clk    = 1'b0;
  logic nreset = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   t        = 0;

  always #5 clk = ~clk;

  i2s_clock_generator_if #(.DIVIDER_WIDTH(8)) u_if ();

  i2s_clock_generator #(
    .DATA_WIDTH   (16),
    .DIVIDER_WIDTH(8)
  ) u_dut (
    .i_CLK   (clk),
    .i_NRESET(nreset),
    .bus     (u_if)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    u_if.i_ENABLE = 1'b0;
    nreset = 1'b0;
    repeat (3) @(negedge clk);
    nreset = 1'b1;
    @(negedge clk);
  endtask

  // Raises enable on a falling edge; the next falling edge samples t0.
  task automatic start(input logic [7:0] div);
    u_if.i_DIVIDER = div;
    u_if.i_ENABLE  = 1'b1;
    @(negedge clk);
    t = 0;
  endtask

  task automatic step_to(input int n);
    while (t < n) begin
      @(negedge clk);
      t++;
    end
  endtask

  int frames, rises, ws_rises, ws_bad;
  logic prev_ws;

  initial begin
    u_if.i_ENABLE  = 1'b0;
    u_if.i_DIVIDER = 8'd0;
    #12;
    check("rst_sck",  u_if.o_SCK, 0);
    check("rst_ws",   u_if.o_WS, 0);
    check("rst_fs",   u_if.o_FRAME_START, 0);
    check("rst_busy", u_if.o_BUSY, 0);
    check("rst_edge", {u_if.o_SCK_RISE, u_if.o_SCK_FALL}, 0);

    // 1: divider 1, period 4, frame 128
    do_reset();
    start(8'd1);
    check("t1_fs0",    u_if.o_FRAME_START, 1);
    check("t1_busy0",  u_if.o_BUSY, 1);
    check("t1_sck0",   u_if.o_SCK, 0);
    step_to(1);   check("t1_sck1", u_if.o_SCK, 0);
    step_to(2);   check("t1_rise2", {u_if.o_SCK, u_if.o_SCK_RISE}, 2'b11);
    step_to(4);   check("t1_fall4", {u_if.o_SCK, u_if.o_SCK_FALL}, 2'b01);
    step_to(63);  check("t1_ws63", u_if.o_WS, 0);
    step_to(64);  check("t1_ws64", u_if.o_WS, 1);
    step_to(127); check("t1_ws127", {u_if.o_WS, u_if.o_FRAME_START}, 2'b10);
    step_to(128); check("t1_fs128", {u_if.o_WS, u_if.o_FRAME_START}, 2'b01);

    // 2: divider 0, maximum rate
    do_reset();
    start(8'd0);
    step_to(1);  check("t2_c1", {u_if.o_SCK, u_if.o_SCK_RISE, u_if.o_SCK_FALL}, 3'b110);
    step_to(2);  check("t2_c2", {u_if.o_SCK, u_if.o_SCK_RISE, u_if.o_SCK_FALL}, 3'b001);
    step_to(3);  check("t2_c3", {u_if.o_SCK, u_if.o_SCK_RISE, u_if.o_SCK_FALL}, 3'b110);
    step_to(31); check("t2_ws31", u_if.o_WS, 0);
    step_to(32); check("t2_ws32", u_if.o_WS, 1);
    step_to(63); check("t2_fs63", u_if.o_FRAME_START, 0);
    step_to(64); check("t2_fs64", u_if.o_FRAME_START, 1);

    // 3: divider change mid-frame takes effect at the boundary
    do_reset();
    start(8'd1);
    step_to(20);  u_if.i_DIVIDER = 8'd3;
    step_to(126); check("t3_sck126", u_if.o_SCK, 1);
    step_to(128); check("t3_fs128", u_if.o_FRAME_START, 1);
    step_to(131); check("t3_sck131", u_if.o_SCK, 0);
    step_to(132); check("t3_rise132", {u_if.o_SCK, u_if.o_SCK_RISE}, 2'b11);
    step_to(136); check("t3_fall136", {u_if.o_SCK, u_if.o_SCK_FALL}, 2'b01);
    step_to(383); check("t3_fs383", u_if.o_FRAME_START, 0);
    step_to(384); check("t3_fs384", u_if.o_FRAME_START, 1);

    // 4a: disable mid-frame drains to the boundary
    do_reset();
    start(8'd1);
    step_to(30);  u_if.i_ENABLE = 1'b0;
    step_to(100); check("t4_busy100", u_if.o_BUSY, 1);
    step_to(126); check("t4_sck126", u_if.o_SCK, 1);
    step_to(128);
    check("t4_end128", {u_if.o_SCK, u_if.o_WS, u_if.o_BUSY, u_if.o_FRAME_START}, 4'b0000);
    check("t4_fall128", u_if.o_SCK_FALL, 1);
    step_to(140); check("t4_idle140", {u_if.o_SCK, u_if.o_BUSY}, 2'b00);

    // 4b: re-enable during drain keeps the frame going
    do_reset();
    start(8'd1);
    step_to(30);  u_if.i_ENABLE = 1'b0;
    step_to(50);  u_if.i_ENABLE = 1'b1;
    step_to(128); check("t4b_fs128", {u_if.o_BUSY, u_if.o_FRAME_START}, 2'b11);
    step_to(130); check("t4b_sck130", u_if.o_SCK, 1);

    // 5: asynchronous reset mid-frame
    do_reset();
    start(8'd1);
    step_to(70);
    check("t5_pre", {u_if.o_SCK, u_if.o_WS}, 2'b11);
    #1 nreset = 1'b0;
    #1;
    check("t5_async", {u_if.o_SCK, u_if.o_WS, u_if.o_BUSY, u_if.o_SCK_RISE,
                       u_if.o_SCK_FALL, u_if.o_FRAME_START}, 6'b0);
    @(negedge clk);
    nreset = 1'b1;
    @(negedge clk);
    t = 0;
    check("t5_restart_fs", {u_if.o_FRAME_START, u_if.o_BUSY, u_if.o_SCK}, 3'b110);
    step_to(2); check("t5_rise2", {u_if.o_SCK, u_if.o_SCK_RISE}, 2'b11);
    step_to(4); check("t5_fall4", {u_if.o_SCK, u_if.o_SCK_FALL}, 2'b01);

    // 6: ten frames at divider 2
    do_reset();
    start(8'd2);
    frames = 0; rises = 0; ws_rises = 0; ws_bad = 0;
    prev_ws = u_if.o_WS;
    for (int i = 0; i < 5000 && frames < 11; i++) begin
      if (u_if.o_WS !== prev_ws && !u_if.o_SCK_FALL) ws_bad++;
      prev_ws = u_if.o_WS;
      if (u_if.o_FRAME_START) begin
        if (frames > 0) begin
          check("t6_rises", rises, 32);
          check("t6_ws_high", ws_rises, 16);
        end
        frames++;
        rises = 0;
        ws_rises = 0;
      end
      if (u_if.o_SCK_RISE) begin
        rises++;
        if (u_if.o_WS) ws_rises++;
      end
      @(negedge clk);
    end
    check("t6_frames", frames, 11);
    check("t6_ws_on_fall", ws_bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
